// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared ibus types, fetch FSM state codes, reset PC and the PC legality check
package fetch_sequencer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam logic [3:0]  SEG_LO   = 4'h8;
    localparam logic [3:0]  SEG_HI   = 4'hb;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // A PC is fetchable when word aligned and its top nibble lies in [lo, hi].
    function automatic logic pc_legal(input logic [31:0] pc, input logic [3:0] lo, input logic [3:0] hi);
        return (pc[1:0] == 2'b00) && (pc[31:28] >= lo) && (pc[31:28] <= hi);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs one ibus fetch at a time and holds the result for decode
//   clk, resetn          clock, asynchronous active-low reset
//   redirect_valid/_pc   replace the fetch stream with a new PC
//   ireq / iresp         instruction bus request {valid, addr} / response {addr_ok, data_ok, data}
//   out_valid/_ready     decode handshake; out_pc, out_instr, out_adel describe the held fetch
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_sequencer_pkg::RESET_PC,
    parameter logic [3:0]  SEG_LO   = fetch_sequencer_pkg::SEG_LO,
    parameter logic [3:0]  SEG_HI   = fetch_sequencer_pkg::SEG_HI
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_adel_q, out_adel_d;
    logic        legal;
    logic        drop;
    logic [31:0] target;

    assign legal = pc_legal(pc_q, SEG_LO, SEG_HI);
    // An accepted request is stale if a redirect arrives now or was recorded while waiting for addr_ok;
    // the newest redirect always wins.
    assign drop   = redirect_valid | kill_q;
    assign target = redirect_valid ? redirect_pc : pend_pc_q;

    // While kill is pending pc_q still holds the old address, so the request stays stable.
    assign ireq.valid = (state_q == S_REQ) && legal;
    assign ireq.addr  = ireq.valid ? pc_q : 32'h0;

    assign out_valid = (state_q == S_HOLD);
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_adel  = out_adel_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        kill_d      = kill_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_adel_d  = out_adel_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                pc_d    = redirect_valid ? redirect_pc : pc_q;
            end
            S_REQ: begin
                if (!legal) begin
                    // No request was issued, so a redirect simply retargets the fetch.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        out_pc_d    = pc_q;
                        out_instr_d = 32'h0;
                        out_adel_d  = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (iresp.addr_ok) begin
                    if (drop) begin
                        pc_d    = target;
                        kill_d  = 1'b0;
                        state_d = iresp.data_ok ? S_REQ : S_DRAIN;
                    end else if (iresp.data_ok) begin
                        out_pc_d    = pc_q;
                        out_instr_d = iresp.data;
                        out_adel_d  = 1'b0;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (redirect_valid) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = iresp.data_ok ? S_REQ : S_DRAIN;
                end else if (iresp.data_ok) begin
                    out_pc_d    = pc_q;
                    out_instr_d = iresp.data;
                    out_adel_d  = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    pc_d    = redirect_valid ? redirect_pc : pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                pc_d    = redirect_valid ? redirect_pc : pc_q;
                state_d = iresp.data_ok ? S_REQ : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pend_pc_q   <= 32'h0;
            kill_q      <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
            out_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            kill_q      <= kill_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_adel_q  <= out_adel_d;
        end
    end

endmodule
